// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the TLB instruction controller: op_type encodings,
// FSM state codes and the packed TLB entry width.
// Imported by tlb_op_ctrl and by anything that drives or consumes its ports.
package tlb_op_ctrl_pkg;

  localparam int TLB_ENTRY_W = 78;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,  // illegal encoding, never accepted
    OP_TLBP  = 2'b01,
    OP_TLBR  = 2'b10,
    OP_TLBWI = 2'b11
  } tlb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10,
    ST_DONE  = 2'b11
  } tlb_state_t;

  localparam logic [31:0] TLBP_MISS_INDEX = 32'h8000_0000;

endpackage

// File: rtl/tlb_op_ctrl.sv
// Sequences tlbp / tlbr / tlbwi against the TLB and CP0.
// Latency: accept to done_valid is 3 cycles (tlbp, tlbr) or 2 cycles (tlbwi).
// Backpressure: op_ready only in IDLE, so one op is in flight at a time.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   op_valid/op_type/op_pc       TLB instruction from the pipeline; op_ready accepts
//   flush                        writeback flush, aborts an op in flight
//   done_valid/refetch/refetch_pc completion pulse and refetch request
//   cp0_entryhi/cp0_index/cp0_tlbwi_entry  CP0 state sampled at accept
//   s_*                          TLB search port (tlbp)
//   r_index/r_entry              TLB read port (tlbr)
//   w_en/w_index/w_entry         TLB write port (tlbwi)
//   tlbp_wen/tlbp_index          CP0 Index update
//   tlbr_wen/tlbr_entry          CP0 EntryHi/EntryLo0/EntryLo1 update
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  input  logic [1:0]             op_type,
  input  logic [31:0]            op_pc,
  output logic                   op_ready,
  input  logic                   flush,
  output logic                   done_valid,
  output logic                   refetch,
  output logic [31:0]            refetch_pc,
  input  logic [31:0]            cp0_entryhi,
  input  logic [31:0]            cp0_index,
  input  logic [TLB_ENTRY_W-1:0] cp0_tlbwi_entry,
  output logic [18:0]            s_vpn2,
  output logic [7:0]             s_asid,
  input  logic                   s_found,
  input  logic [IW-1:0]          s_index,
  output logic                   s_req,
  output logic [IW-1:0]          r_index,
  input  logic [TLB_ENTRY_W-1:0] r_entry,
  output logic                   w_en,
  output logic [IW-1:0]          w_index,
  output logic [TLB_ENTRY_W-1:0] w_entry,
  output logic                   tlbp_wen,
  output logic [31:0]            tlbp_index,
  output logic                   tlbr_wen,
  output logic [TLB_ENTRY_W-1:0] tlbr_entry
);

  tlb_state_t             state_q, state_d;
  tlb_op_t                op_q;
  logic [31:0]            pc_q;
  logic [IW-1:0]          idx_q;
  logic [18:0]            vpn2_q;
  logic [7:0]             asid_q;
  logic [TLB_ENTRY_W-1:0] wentry_q;
  logic                   accept;

  // Bits of CP0 registers this block has no use for.
  logic unused_cp0;
  assign unused_cp0 = ^{cp0_entryhi[12:8], cp0_index[31:IW]};

  assign op_ready = (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready && (op_type != OP_NONE) && !flush;

  // CP0 operands are captured at accept so that the TLB ports present stable,
  // registered values in ISSUE and r_index stays put through RESP while the
  // read data comes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      pc_q     <= '0;
      idx_q    <= '0;
      vpn2_q   <= '0;
      asid_q   <= '0;
      wentry_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= tlb_op_t'(op_type);
        pc_q     <= op_pc;
        idx_q    <= cp0_index[IW-1:0];
        vpn2_q   <= cp0_entryhi[31:13];
        asid_q   <= cp0_entryhi[7:0];
        wentry_q <= cp0_tlbwi_entry;
      end
    end
  end

  assign s_vpn2     = vpn2_q;
  assign s_asid     = asid_q;
  assign r_index    = idx_q;
  assign w_index    = idx_q;
  assign w_entry    = wentry_q;
  assign refetch_pc = pc_q + 32'd4;

  // Search and read responses arrive in RESP itself, so the CP0 write data
  // is steered straight from the TLB return path rather than re-registered.
  assign tlbp_index = s_found ? {{(32-IW){1'b0}}, s_index} : TLBP_MISS_INDEX;
  assign tlbr_entry = r_entry;

  always_comb begin
    state_d    = state_q;
    s_req      = 1'b0;
    w_en       = 1'b0;
    tlbp_wen   = 1'b0;
    tlbr_wen   = 1'b0;
    done_valid = 1'b0;
    refetch    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end

      // TLB-side strobes in ISSUE go out even on a flush cycle: the request
      // has already left this cycle, the flush only stops what follows.
      ST_ISSUE: begin
        s_req = (op_q == OP_TLBP);
        w_en  = (op_q == OP_TLBWI);
        if (flush)                 state_d = ST_IDLE;
        else if (op_q == OP_TLBWI) state_d = ST_DONE;
        else                       state_d = ST_RESP;
      end

      // CP0 writes in RESP commit architectural state, so a flush arriving
      // with them must cancel them.
      ST_RESP: begin
        tlbp_wen = (op_q == OP_TLBP) && !flush;
        tlbr_wen = (op_q == OP_TLBR) && !flush;
        state_d  = flush ? ST_IDLE : ST_DONE;
      end

      ST_DONE: begin
        done_valid = !flush;
        refetch    = !flush && (op_q != OP_TLBP);
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   op_valid;
  logic [1:0]             op_type;
  logic [31:0]            op_pc;
  logic                   op_ready;
  logic                   flush;
  logic                   done_valid;
  logic                   refetch;
  logic [31:0]            refetch_pc;
  logic [31:0]            cp0_entryhi;
  logic [31:0]            cp0_index;
  logic [TLB_ENTRY_W-1:0] cp0_tlbwi_entry;
  logic [18:0]            s_vpn2;
  logic [7:0]             s_asid;
  logic                   s_found;
  logic [IW-1:0]          s_index;
  logic                   s_req;
  logic [IW-1:0]          r_index;
  logic [TLB_ENTRY_W-1:0] r_entry;
  logic                   w_en;
  logic [IW-1:0]          w_index;
  logic [TLB_ENTRY_W-1:0] w_entry;
  logic                   tlbp_wen;
  logic [31:0]            tlbp_index;
  logic                   tlbr_wen;
  logic [TLB_ENTRY_W-1:0] tlbr_entry;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_type(op_type), .op_pc(op_pc), .op_ready(op_ready),
    .flush(flush),
    .done_valid(done_valid), .refetch(refetch), .refetch_pc(refetch_pc),
    .cp0_entryhi(cp0_entryhi), .cp0_index(cp0_index), .cp0_tlbwi_entry(cp0_tlbwi_entry),
    .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index), .s_req(s_req),
    .r_index(r_index), .r_entry(r_entry),
    .w_en(w_en), .w_index(w_index), .w_entry(w_entry),
    .tlbp_wen(tlbp_wen), .tlbp_index(tlbp_index),
    .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry)
  );

  always #5 clk = ~clk;

  // Small TLB model: one-cycle search and read latency.
  logic [18:0]            vpn2_tab [TLBNUM];
  logic [7:0]             asid_tab [TLBNUM];
  logic [TLB_ENTRY_W-1:0] data_tab [TLBNUM];
  logic                   hit;
  logic [IW-1:0]          hit_idx;

  always @(posedge clk) begin
    r_entry <= data_tab[r_index];
    if (s_req) begin
      hit     = 1'b0;
      hit_idx = 4'hA;  // junk index on a miss
      for (int i = 0; i < TLBNUM; i++)
        if (vpn2_tab[i] == s_vpn2 && asid_tab[i] == s_asid) begin
          hit     = 1'b1;
          hit_idx = i[IW-1:0];
        end
      s_found <= hit;
      s_index <= hit_idx;
    end
  end

  // Pulse counters for strobes and completions.
  int n_wen = 0, n_pwen = 0, n_rwen = 0, n_done = 0;
  always @(negedge clk) begin
    if (w_en)       n_wen++;
    if (tlbp_wen)   n_pwen++;
    if (tlbr_wen)   n_rwen++;
    if (done_valid) n_done++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] t, input logic [31:0] pc);
    op_valid = 1'b1;
    op_type  = t;
    op_pc    = pc;
    check("op_ready_at_accept", op_ready, 1'b1);
    tick();
    op_valid = 1'b0;
    op_type  = 2'b00;
  endtask

  int b_wen, b_pwen, b_rwen, b_done;
  task automatic snap();
    b_wen = n_wen; b_pwen = n_pwen; b_rwen = n_rwen; b_done = n_done;
  endtask

  initial begin
    rst = 1'b1;
    op_valid = 1'b0; op_type = 2'b00; op_pc = '0; flush = 1'b0;
    cp0_entryhi = '0; cp0_index = '0; cp0_tlbwi_entry = '0;
    s_found = 1'b0; s_index = '0; r_entry = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      vpn2_tab[i] = 19'h7_0000 + 19'(i);
      asid_tab[i] = 8'h11;
      data_tab[i] = '0;
    end
    vpn2_tab[5] = 19'h00201;  // EntryHi 0x004020FF -> VPN2 0x201
    asid_tab[5] = 8'hFF;
    data_tab[3] = 78'h3ABC_DEF0_1234_5678_9ABC;

    repeat (3) tick();
    check("rst_op_ready", op_ready, 1'b1);
    check("rst_w_en", w_en, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_op_ready", op_ready, 1'b1);
    check("post_rst_done", done_valid, 1'b0);
    check("post_rst_refetch", refetch, 1'b0);
    check("post_rst_strobes", {s_req, w_en, tlbp_wen, tlbr_wen}, 4'b0000);
    check("post_rst_refetch_pc", refetch_pc, 32'h0000_0004);

    // tlbp hit at index 5
    cp0_entryhi = 32'h0040_20FF;
    snap();
    start_op(2'b01, 32'h8000_1000);
    check("p_hit_issue_s_req", s_req, 1'b1);
    check("p_hit_issue_vpn2", s_vpn2, 19'h00201);
    check("p_hit_issue_asid", s_asid, 8'hFF);
    check("p_hit_issue_ready", op_ready, 1'b0);
    tick();
    check("p_hit_resp_wen", tlbp_wen, 1'b1);
    check("p_hit_resp_index", tlbp_index, 32'h0000_0005);
    check("p_hit_resp_s_req", s_req, 1'b0);
    check("p_hit_resp_done", done_valid, 1'b0);
    tick();
    check("p_hit_done_valid", done_valid, 1'b1);
    check("p_hit_done_refetch", refetch, 1'b0);
    tick();
    check("p_hit_after_done", done_valid, 1'b0);

    // tlbp miss, accepted back-to-back the cycle after DONE
    cp0_entryhi = 32'h1234_5678;
    start_op(2'b01, 32'h8000_2000);
    tick();
    check("p_miss_index", tlbp_index, 32'h8000_0000);
    check("p_miss_wen", tlbp_wen, 1'b1);
    tick();
    check("p_miss_done", done_valid, 1'b1);
    tick();
    check("p_pair_done_count", n_done - b_done, 2);
    check("p_pair_pwen_count", n_pwen - b_pwen, 2);
    check("p_no_rwen", n_rwen - b_rwen, 0);
    check("p_no_wen", n_wen - b_wen, 0);

    // tlbr index 3
    cp0_index = 32'd3;
    snap();
    start_op(2'b10, 32'hBFC0_0100);
    check("r_issue_index", r_index, 4'd3);
    check("r_issue_no_rwen", tlbr_wen, 1'b0);
    tick();
    check("r_resp_rwen", tlbr_wen, 1'b1);
    check("r_resp_entry", tlbr_entry, 78'h3ABC_DEF0_1234_5678_9ABC);
    check("r_resp_index_held", r_index, 4'd3);
    tick();
    check("r_done_valid", done_valid, 1'b1);
    check("r_done_refetch", refetch, 1'b1);
    check("r_done_pc", refetch_pc, 32'hBFC0_0104);
    tick();
    check("r_one_rwen", n_rwen - b_rwen, 1);

    // tlbwi index 15, PC wrap
    cp0_index = 32'd15;
    cp0_tlbwi_entry = 78'h1122_3344_5566_7788_99AA;
    snap();
    start_op(2'b11, 32'hFFFF_FFFC);
    check("w_issue_wen", w_en, 1'b1);
    check("w_issue_index", w_index, 4'd15);
    check("w_issue_entry", w_entry, 78'h1122_3344_5566_7788_99AA);
    tick();
    check("w_done_valid", done_valid, 1'b1);
    check("w_done_refetch", refetch, 1'b1);
    check("w_done_pc", refetch_pc, 32'h0000_0000);
    check("w_done_wen_low", w_en, 1'b0);
    tick();
    check("w_one_wen", n_wen - b_wen, 1);
    check("w_one_done", n_done - b_done, 1);

    // illegal op_type and op offered under flush are both ignored
    snap();
    op_valid = 1'b1; op_type = 2'b00;
    tick();
    check("ill_stays_idle", op_ready, 1'b1);
    op_type = 2'b11; flush = 1'b1;
    tick();
    op_valid = 1'b0; op_type = 2'b00; flush = 1'b0;
    check("flush_accept_idle", op_ready, 1'b1);
    tick(); tick();
    check("ignored_no_wen", n_wen - b_wen, 0);
    check("ignored_no_done", n_done - b_done, 0);

    // flush in RESP of tlbr
    cp0_index = 32'd3;
    snap();
    start_op(2'b10, 32'h0000_0040);
    tick();
    flush = 1'b1;
    #1;
    check("rf_resp_no_rwen", tlbr_wen, 1'b0);
    tick();
    flush = 1'b0;
    check("rf_ready_next", op_ready, 1'b1);
    check("rf_no_done_now", done_valid, 1'b0);
    tick(); tick();
    check("rf_rwen_count", n_rwen - b_rwen, 0);
    check("rf_done_count", n_done - b_done, 0);

    // flush in ISSUE of tlbwi: the write already driven still goes out
    cp0_index = 32'd7;
    snap();
    start_op(2'b11, 32'h0000_0080);
    flush = 1'b1;
    #1;
    check("wf_issue_wen", w_en, 1'b1);
    tick();
    flush = 1'b0;
    check("wf_ready_next", op_ready, 1'b1);
    tick(); tick();
    check("wf_wen_count", n_wen - b_wen, 1);
    check("wf_done_count", n_done - b_done, 0);

    // flush in DONE of tlbp
    cp0_entryhi = 32'h0040_20FF;
    snap();
    start_op(2'b01, 32'h0000_0100);
    tick(); tick();
    flush = 1'b1;
    #1;
    check("df_done_suppressed", done_valid, 1'b0);
    check("df_refetch_suppressed", refetch, 1'b0);
    tick();
    flush = 1'b0;
    check("df_ready_next", op_ready, 1'b1);
    check("df_done_count", n_done - b_done, 0);

    // reset in ISSUE of tlbwi
    cp0_index = 32'd15;
    snap();
    start_op(2'b11, 32'h0000_0200);
    check("rs_issue_wen", w_en, 1'b1);
    rst = 1'b1;
    #1;
    check("rs_wen_dropped", w_en, 1'b0);
    check("rs_idle", op_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("rs_wen_count", n_wen - b_wen, 0);
    check("rs_done_count", n_done - b_done, 0);
    check("rs_refetch_pc", refetch_pc, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
